// File: rtl/mdr_pkg.sv
// mdr_pkg: state encoding and default sizing for the memory data register.
package mdr_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/mdr_timeout_cnt.sv
// mdr_timeout_cnt: counts REQ cycles and flags the last permitted one.
module mdr_timeout_cnt
    import mdr_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mdr_ctrl.sv
// mdr_ctrl: MDR loaded from an internal bus or from memory via req/ack with timeout.
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = (NUM_SRC > 1 ? $clog2(NUM_SRC) : 1),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      load,
    input  logic                      mem_rd_start,
    output logic                      mem_req,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [DATA_W-1:0]         mdr_out,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
);
    state_t             state;
    logic               expired;
    logic               sel_ok;
    logic [DATA_W-1:0]  sel_data;
    assign sel_ok   = 32'(src_sel) < NUM_SRC;
    assign sel_data = DATA_W'(src_data >> (32'(src_sel) * DATA_W));
    assign busy     = state != IDLE;
    // counter is held at zero outside REQ so every request starts fresh
    mdr_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != REQ),
        .en     (state == REQ),
        .expired(expired)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mdr_out     <= '0;
            mem_req     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_rd_start) begin
                        state       <= REQ;
                        mem_req     <= 1'b1;
                        timeout_err <= 1'b0;
                    end else if (load && sel_ok) begin
                        mdr_out <= sel_data;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mdr_out <= mem_data;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdr_ctrl.sv
// tb_mdr_ctrl: directed checks of internal loads, memory reads, timeout and reset.
module tb_mdr_ctrl;
    localparam int DATA_W  = 16;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 15;
    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_SRC*DATA_W-1:0] src_data = '0;
    logic [SEL_W-1:0]          src_sel = '0;
    logic                      load = 1'b0;
    logic                      mem_rd_start = 1'b0;
    logic                      mem_req;
    logic                      mem_ack = 1'b0;
    logic [DATA_W-1:0]         mem_data = '0;
    logic [DATA_W-1:0]         mdr_out;
    logic                      busy;
    logic                      done;
    logic                      timeout_err;
    int tests = 0;
    int fails = 0;
    int n;

    mdr_ctrl #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_data    (src_data),
        .src_sel     (src_sel),
        .load        (load),
        .mem_rd_start(mem_rd_start),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .mdr_out     (mdr_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        chk("rst_mdr", 32'(mdr_out), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        #2 rst_n = 1'b1;
        step();
        // reset asserted mid-REQ
        mem_rd_start = 1'b1;
        step();
        mem_rd_start = 1'b0;
        chk("req_up", 32'(mem_req), 32'h1);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_mdr", 32'(mdr_out), 32'h0);
        chk("midrst_terr", 32'(timeout_err), 32'h0);
        #2 rst_n = 1'b1;
        step();
        // internal loads
        src_data = {16'h5A5A, 16'hBEEF, 16'h1234};
        src_sel = 2'd1;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("load_sel1", 32'(mdr_out), 32'hBEEF);
        chk("load_busy", 32'(busy), 32'h0);
        src_sel = 2'd3;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("load_oob_hold", 32'(mdr_out), 32'hBEEF);
        src_sel = 2'd2;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("load_sel2", 32'(mdr_out), 32'h5A5A);
        // memory read, ack on third REQ cycle
        mem_rd_start = 1'b1;
        step();
        mem_rd_start = 1'b0;
        chk("rd_req1", 32'(mem_req), 32'h1);
        chk("rd_busy", 32'(busy), 32'h1);
        step();
        chk("rd_req2", 32'(mem_req), 32'h1);
        step();
        chk("rd_req3", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        mem_data = 16'hA5A5;
        step();
        mem_ack = 1'b0;
        chk("rd_mdr", 32'(mdr_out), 32'hA5A5);
        chk("rd_done", 32'(done), 32'h1);
        chk("rd_req_off", 32'(mem_req), 32'h0);
        step();
        chk("rd_done_clr", 32'(done), 32'h0);
        chk("rd_idle", 32'(busy), 32'h0);
        // timeout with no ack
        mem_rd_start = 1'b1;
        step();
        mem_rd_start = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_mdr_hold", 32'(mdr_out), 32'hA5A5);
        chk("to_idle", 32'(busy), 32'h0);
        chk("to_no_done", 32'(done), 32'h0);
        mem_rd_start = 1'b1;
        step();
        mem_rd_start = 1'b0;
        chk("to_err_clr", 32'(timeout_err), 32'h0);
        mem_ack = 1'b1;
        mem_data = 16'h1111;
        step();
        mem_ack = 1'b0;
        chk("to_next_mdr", 32'(mdr_out), 32'h1111);
        step();
        // ack on the timeout cycle
        mem_rd_start = 1'b1;
        step();
        mem_rd_start = 1'b0;
        repeat (14) step();
        chk("edge_req15", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        mem_data = 16'hC3C3;
        step();
        mem_ack = 1'b0;
        chk("edge_mdr", 32'(mdr_out), 32'hC3C3);
        chk("edge_done", 32'(done), 32'h1);
        chk("edge_terr", 32'(timeout_err), 32'h0);
        step();
        chk("edge_terr2", 32'(timeout_err), 32'h0);
        chk("edge_idle", 32'(busy), 32'h0);
        // start+load together, then load during REQ
        mem_rd_start = 1'b1;
        load = 1'b1;
        src_sel = 2'd1;
        step();
        mem_rd_start = 1'b0;
        chk("sim_busy", 32'(busy), 32'h1);
        chk("sim_mdr", 32'(mdr_out), 32'hC3C3);
        src_sel = 2'd0;
        step();
        load = 1'b0;
        chk("reqload_mdr", 32'(mdr_out), 32'hC3C3);
        mem_ack = 1'b1;
        mem_data = 16'h7E7E;
        step();
        mem_ack = 1'b0;
        chk("sim_rd_mdr", 32'(mdr_out), 32'h7E7E);
        chk("sim_done", 32'(done), 32'h1);
        step();
        // stray ack in IDLE
        mem_ack = 1'b1;
        mem_data = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_ign", 32'(mdr_out), 32'h7E7E);
        chk("idle_ack_busy", 32'(busy), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
